// File: rtl/gcd_sched.sv
// Round-robin front end that time-shares one GCD core among NREQ requesters.
// Zero operands bypass the core; a hung core is abandoned after TMO WAIT cycles.
`timescale 1ns/1ps
module gcd_sched #(
   parameter int NREQ = 4,
   parameter int TMO  = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*8-1:0] opa,
   input  logic [NREQ*8-1:0] opb,
   output logic [NREQ-1:0]   gnt,
   output logic [7:0]        rslt,
   output logic [NREQ-1:0]   rslt_vld,
   output logic              rslt_err,
   output logic              busy,
   output logic              core_rst,
   output logic              core_load,
   output logic [7:0]        core_din,
   input  logic [7:0]        core_rslt,
   input  logic              core_done
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(TMO + 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_OPA  = 3'd2;
   localparam logic [2:0] S_OPB  = 3'd3;
   localparam logic [2:0] S_WAIT = 3'd4;
   localparam logic [2:0] S_RESP = 3'd5;

   logic [2:0]    r_state;
   logic [1:0]    r_sync;
   logic [IW-1:0] r_ptr;
   logic [IW-1:0] r_win;
   logic [7:0]    r_opa;
   logic [7:0]    r_opb;
   logic [7:0]    r_rslt;
   logic          r_err;
   logic [CW-1:0] r_cnt;

   logic [IW-1:0] w_win;
   logic [IW-1:0] w_ptr_nxt;
   logic          w_found;
   int            w_idx;
   logic          w_grant;
   logic [7:0]    w_a;
   logic [7:0]    w_b;
   logic          w_tmo;

   // Search upward from the pointer, wrapping at NREQ.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = int'(r_ptr) + k;
         if (w_idx >= NREQ) w_idx = w_idx - NREQ;
         if (!w_found && req[IW'(w_idx)]) begin
            w_found = 1'b1;
            w_win   = IW'(w_idx);
         end
      end
   end

   assign w_ptr_nxt = (int'(w_win) == NREQ - 1) ? '0 : w_win + IW'(1);
   assign w_grant   = (r_state == S_IDLE) && r_sync[1] && w_found;
   assign w_a       = opa[{w_win, 3'b000} +: 8];
   assign w_b       = opb[{w_win, 3'b000} +: 8];
   assign w_tmo     = (r_state == S_WAIT) && !core_done && (r_cnt == CW'(TMO));

   // Reset release is resynchronised before the FSM may leave IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sync <= 2'b00;
      else        r_sync <= {r_sync[0], 1'b1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_ptr   <= '0;
         r_win   <= '0;
         r_opa   <= '0;
         r_opb   <= '0;
         r_rslt  <= '0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_grant) begin
               r_win <= w_win;
               r_ptr <= w_ptr_nxt;
               r_opa <= w_a;
               r_opb <= w_b;
               if (w_a == 8'd0 || w_b == 8'd0) begin
                  r_rslt  <= w_a | w_b;
                  r_err   <= 1'b0;
                  r_state <= S_RESP;
               end else begin
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: r_state <= S_OPA;
            S_OPA:  r_state <= S_OPB;
            S_OPB: begin
               r_cnt   <= CW'(1);
               r_state <= S_WAIT;
            end
            // done wins over timeout on the final count
            S_WAIT: begin
               if (core_done) begin
                  r_rslt  <= core_rslt;
                  r_err   <= 1'b0;
                  r_state <= S_RESP;
               end else if (w_tmo) begin
                  r_rslt  <= 8'd0;
                  r_err   <= 1'b1;
                  r_state <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_RESP:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign gnt       = w_grant ? (NREQ'(1) << w_win) : '0;
   assign rslt_vld  = (r_state == S_RESP) ? (NREQ'(1) << r_win) : '0;
   assign rslt_err  = (r_state == S_RESP) && r_err;
   assign rslt      = r_rslt;
   assign busy      = (r_state != S_IDLE);
   assign core_rst  = !rst_n || w_tmo;
   assign core_load = (r_state == S_LOAD);
   assign core_din  = (r_state == S_OPA) ? r_opa :
                      (r_state == S_OPB) ? r_opb : 8'd0;

endmodule

// File: tb/tb_gcd_sched.sv
// Directed bench for gcd_sched: a behavioural GCD core plus a result scoreboard.
`timescale 1ns/1ps
module tb_gcd_sched;

   localparam int NREQ = 4;
   localparam int TMO  = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [31:0] opa, opb;
   logic [3:0]  gnt, rslt_vld;
   logic [7:0]  rslt, core_din, core_rslt;
   logic        rslt_err, busy, core_rst, core_load, core_done;

   gcd_sched #(.NREQ(NREQ), .TMO(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .opa(opa), .opb(opb),
      .gnt(gnt), .rslt(rslt), .rslt_vld(rslt_vld), .rslt_err(rslt_err),
      .busy(busy), .core_rst(core_rst), .core_load(core_load),
      .core_din(core_din), .core_rslt(core_rslt), .core_done(core_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Behavioural core: takes A then B after the load strobe; done is a level
   // that stays high until the next operation's operands are in.
   bit   hang = 1'b0;
   int   dly  = 3;
   int   ph, cc;
   logic [7:0] ma, mb;

   function automatic logic [7:0] gcd(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] t;
      while (b != 0) begin t = b; b = a % b; a = t; end
      return a;
   endfunction

   always @(posedge clk) begin
      if (core_rst) begin
         core_done <= 1'b0; core_rslt <= 8'd0; ph <= 0; cc <= 0;
      end else begin
         case (ph)
            0: if (core_load) ph <= 1;
            1: begin ma <= core_din; ph <= 2; end
            2: begin mb <= core_din; ph <= 3; cc <= 0; core_done <= 1'b0; end
            3: if (!hang) begin
               if (cc + 1 >= dly) begin
                  core_done <= 1'b1; core_rslt <= gcd(ma, mb); ph <= 0;
               end else cc <= cc + 1;
            end
            default: ph <= 0;
         endcase
      end
   end

   typedef struct { int idx; logic [7:0] r; logic e; } exp_t;
   exp_t sb[$];

   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && rslt_vld !== 4'b0) begin
         if (sb.size() == 0) chk("unexpected_rslt_vld", rslt_vld, 0);
         else begin
            e = sb.pop_front();
            chk("rslt_vld", rslt_vld, 32'(1) << e.idx);
            chk("rslt", rslt, e.r);
            chk("rslt_err", rslt_err, e.e);
         end
      end
   end

   task automatic set_req(input int idx, input logic [7:0] a, input logic [7:0] b);
      req[idx] = 1'b1;
      opa[idx*8 +: 8] = a;
      opb[idx*8 +: 8] = b;
   endtask

   // Waits for the grant, queues the expected answer, drops req after capture.
   task automatic serve(input int idx, input logic [7:0] r, input logic e, input bit push);
      int n = 0;
      while (gnt[idx] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      chk($sformatf("gnt%0d", idx), gnt, 32'(1) << idx);
      if (push) sb.push_back('{idx, r, e});
      @(posedge clk); #1;
      req[idx] = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 200) begin @(negedge clk); n++; end
      chk("idle_reached", busy, 0);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_gnt", gnt, 0);
      chk("rst_vld", rslt_vld, 0);
      chk("rst_rslt", rslt, 0);
      chk("rst_err", rslt_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_load", core_load, 0);
      chk("rst_din", core_din, 0);
      chk("rst_core_rst", core_rst, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, rst_cnt, rst_at;
      rst_n = 1'b0; req = '0; opa = '0; opb = '0;
      repeat (2) @(negedge clk);
      chk_reset_outputs();

      // Single request through the core, with request pending across reset release.
      set_req(0, 8'd27, 8'd18);
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk); chk("sync_gnt_a", gnt, 0);
      @(negedge clk); chk("sync_gnt_b", gnt, 0);
      serve(0, 8'd9, 1'b0, 1);
      @(negedge clk); chk("load_strobe", core_load, 1); chk("load_din", core_din, 0);
      @(negedge clk); chk("opa_load", core_load, 0);   chk("opa_din", core_din, 27);
      @(negedge clk); chk("opb_load", core_load, 0);   chk("opb_din", core_din, 18);
      wait_idle();
      chk("rslt_hold", rslt, 9);
      chk("din_idle", core_din, 0);

      // Contention from a fresh reset: order 0,1,2,3, last one bypassed.
      @(posedge clk); #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      set_req(0, 8'd12, 8'd8); set_req(1, 8'd35, 8'd21);
      set_req(2, 8'd17, 8'd5); set_req(3, 8'd0, 8'd0);
      serve(0, 8'd4, 1'b0, 1);
      serve(1, 8'd7, 1'b0, 1);
      serve(2, 8'd1, 1'b0, 1);
      serve(3, 8'd0, 1'b0, 1);
      @(negedge clk); chk("bypass_latency", rslt_vld, 4'b1000);
      wait_idle();

      // Fairness: requester 2 served, then 0 and 2 together -> 0 first.
      @(posedge clk); #1 set_req(2, 8'd6, 8'd4);
      serve(2, 8'd2, 1'b0, 1);
      wait_idle();
      @(posedge clk); #1;
      set_req(0, 8'd14, 8'd21); set_req(2, 8'd0, 8'd5);
      serve(0, 8'd7, 1'b0, 1);
      serve(2, 8'd5, 1'b0, 1);
      wait_idle();

      // Stale done: core still shows done=1 with result 7 from the last op.
      dly = 4;
      @(posedge clk); #1 set_req(1, 8'd20, 8'd8);
      serve(1, 8'd4, 1'b0, 1);
      @(negedge clk); chk("stale_done_seen", core_done, 1);
      wait_idle();

      // Reset while the core hangs in WAIT: no response must ever appear.
      hang = 1'b1;
      @(posedge clk); #1 set_req(0, 8'd9, 8'd6);
      serve(0, 8'd0, 1'b0, 0);
      repeat (5) @(negedge clk);
      chk("pre_rst_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1; hang = 1'b0;
      repeat (TMO + 10) @(negedge clk);
      chk("no_resp_after_rst", sb.size(), 0);

      // Timeout: core never answers.
      hang = 1'b1;
      @(posedge clk); #1 set_req(1, 8'd9, 8'd6);
      serve(1, 8'd0, 1'b1, 1);
      n = 0; rst_cnt = 0; rst_at = 0;
      while (n < 200) begin
         @(negedge clk); n++;
         if (core_rst) begin rst_cnt++; rst_at = n; end
         if (rslt_vld != 0) break;
      end
      chk("tmo_latency", n, TMO + 4);
      chk("tmo_core_rst_cnt", rst_cnt, 1);
      chk("tmo_core_rst_pos", rst_at, TMO + 3);
      hang = 1'b0;
      wait_idle();
      chk("sb_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
